// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard controller: FSM state encoding,
// EX-operand forwarding selects and the hard-wired zero register index.
package hazard_pkg;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        LDUSE   = 2'd1,
        MEMWAIT = 2'd2,
        BFLUSH  = 2'd3
    } hz_state_t;

    typedef enum logic [1:0] {
        FWD_REG = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_t;

    localparam int unsigned REG_ZERO = 0;

endpackage

// File: rtl/hazard_ctrl_fwd_select.sv
// Forwarding select for one EX source operand: the Memory stage result wins
// over the Writeback result, and register 0 never forwards.
module fwd_select
    import hazard_pkg::*;
#(
    parameter int REG_AW = 4
) (
    input  logic [REG_AW-1:0] src_i,
    input  logic [REG_AW-1:0] wa_m_i,
    input  logic              we_m_i,
    input  logic [REG_AW-1:0] wa_w_i,
    input  logic              we_w_i,
    output fwd_t              fwd_o
);

    localparam logic [REG_AW-1:0] ZERO = REG_AW'(REG_ZERO);

    logic hit_m;
    logic hit_w;

    assign hit_m = we_m_i && (wa_m_i == src_i) && (src_i != ZERO);
    assign hit_w = we_w_i && (wa_w_i == src_i) && (src_i != ZERO);

    always_comb begin
        if (hit_m) begin
            fwd_o = FWD_MEM;
        end else if (hit_w) begin
            fwd_o = FWD_WB;
        end else begin
            fwd_o = FWD_REG;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: stall/flush strobes for the stage buffers and
// EX forwarding selects. Define HAZARD_FWD_EN to enable operand forwarding.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_AW       = 4,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] RA1D,
    input  logic [REG_AW-1:0] RA2D,
    input  logic [REG_AW-1:0] RA1E,
    input  logic [REG_AW-1:0] RA2E,
    input  logic [REG_AW-1:0] WA3E,
    input  logic [REG_AW-1:0] WA3M,
    input  logic [REG_AW-1:0] WA3W,
    input  logic              RegWriteE,
    input  logic              RegWriteM,
    input  logic              RegWriteW,
    input  logic              MemtoRegE,
    input  logic              BranchTakenE,
    input  logic              mem_busy,
    output logic              StallF,
    output logic              StallD,
    output logic              StallE,
    output logic              StallM,
    output logic              FlushD,
    output logic              FlushE,
    output fwd_t              ForwardAE,
    output fwd_t              ForwardBE,
    output logic [1:0]        state_o
);

    localparam logic [REG_AW-1:0] ZERO     = REG_AW'(REG_ZERO);
    localparam logic [2:0]        CNT_LOAD = 3'(FLUSH_CYCLES - 1);

    hz_state_t  state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic       stall_fd, stall_em, flush_d, flush_e;
    logic       d_hazard;
    logic       hit_e;
    fwd_t       fwd_a, fwd_b;

    assign hit_e = RegWriteE && (((WA3E == RA1D) && (RA1D != ZERO)) ||
                                 ((WA3E == RA2D) && (RA2D != ZERO)));

`ifdef HAZARD_FWD_EN
    localparam hz_state_t HAZ_NEXT = LDUSE;

    assign d_hazard = MemtoRegE && hit_e;

    fwd_select #(.REG_AW(REG_AW)) u_fwd_a (
        .src_i  (RA1E),
        .wa_m_i (WA3M),
        .we_m_i (RegWriteM),
        .wa_w_i (WA3W),
        .we_w_i (RegWriteW),
        .fwd_o  (fwd_a)
    );

    fwd_select #(.REG_AW(REG_AW)) u_fwd_b (
        .src_i  (RA2E),
        .wa_m_i (WA3M),
        .we_m_i (RegWriteM),
        .wa_w_i (WA3W),
        .we_w_i (RegWriteW),
        .fwd_o  (fwd_b)
    );
`else
    // Without forwarding any pending E/M write stalls; W writes first half-cycle.
    localparam hz_state_t HAZ_NEXT = RUN;

    logic hit_m;
    logic unused_fwd_inputs;

    assign hit_m = RegWriteM && (((WA3M == RA1D) && (RA1D != ZERO)) ||
                                 ((WA3M == RA2D) && (RA2D != ZERO)));
    assign d_hazard = hit_e || hit_m;
    assign fwd_a    = FWD_REG;
    assign fwd_b    = FWD_REG;
    assign unused_fwd_inputs = ^{RA1E, RA2E, WA3W, RegWriteW, MemtoRegE};
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        stall_fd = 1'b0;
        stall_em = 1'b0;
        flush_d  = 1'b0;
        flush_e  = 1'b0;
        if (state_q == BFLUSH) begin
            // Branches and load-use inside the window belong to flushed instructions.
            if (mem_busy) begin
                stall_fd = 1'b1;
                stall_em = 1'b1;
            end else begin
                flush_d = (cnt_q != 3'd0);
                flush_e = (cnt_q != 3'd0);
                cnt_d   = (cnt_q != 3'd0) ? cnt_q - 3'd1 : 3'd0;
                if (cnt_q <= 3'd1) begin
                    state_d = RUN;
                end
            end
        end else if (BranchTakenE) begin
            flush_d = 1'b1;
            flush_e = 1'b1;
            cnt_d   = CNT_LOAD;
            state_d = (CNT_LOAD != 3'd0) ? BFLUSH : RUN;
        end else if (mem_busy) begin
            stall_fd = 1'b1;
            stall_em = 1'b1;
            state_d  = MEMWAIT;
        end else if (state_q == LDUSE) begin
            state_d = RUN;
        end else if (d_hazard) begin
            stall_fd = 1'b1;
            flush_e  = 1'b1;
            state_d  = HAZ_NEXT;
        end else begin
            state_d = RUN;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= RUN;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Flushes stay high for the whole reset so every stage buffer clears.
    assign StallF    = reset & stall_fd;
    assign StallD    = reset & stall_fd;
    assign StallE    = reset & stall_em;
    assign StallM    = reset & stall_em;
    assign FlushD    = ~reset | flush_d;
    assign FlushE    = ~reset | flush_e;
    assign ForwardAE = reset ? fwd_a : FWD_REG;
    assign ForwardBE = reset ? fwd_b : FWD_REG;
    assign state_o   = state_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl; expectations follow the HAZARD_FWD_EN setting
// of the build.
module tb_hazard_ctrl;
    import hazard_pkg::*;

`ifdef HAZARD_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W;
    logic       RegWriteE, RegWriteM, RegWriteW, MemtoRegE, BranchTakenE, mem_busy;
    logic       StallF, StallD, StallE, StallM, FlushD, FlushE;
    logic [1:0] ForwardAE, ForwardBE, state_o;
    logic [5:0] strb;
    logic [5:0] exp_strb;
    logic [1:0] exp_st;
    logic [1:0] exp_fwd;
    int         n_cmp = 0;
    int         n_bad = 0;

    hazard_ctrl #(.REG_AW(4), .FLUSH_CYCLES(2)) dut (
        .clk          (clk),
        .reset        (reset),
        .RA1D         (RA1D),
        .RA2D         (RA2D),
        .RA1E         (RA1E),
        .RA2E         (RA2E),
        .WA3E         (WA3E),
        .WA3M         (WA3M),
        .WA3W         (WA3W),
        .RegWriteE    (RegWriteE),
        .RegWriteM    (RegWriteM),
        .RegWriteW    (RegWriteW),
        .MemtoRegE    (MemtoRegE),
        .BranchTakenE (BranchTakenE),
        .mem_busy     (mem_busy),
        .StallF       (StallF),
        .StallD       (StallD),
        .StallE       (StallE),
        .StallM       (StallM),
        .FlushD       (FlushD),
        .FlushE       (FlushE),
        .ForwardAE    (ForwardAE),
        .ForwardBE    (ForwardBE),
        .state_o      (state_o)
    );

    always #5 clk = ~clk;

    // Strobes packed as {StallF,StallD,StallE,StallM,FlushD,FlushE}.
    assign strb = {StallF, StallD, StallE, StallM, FlushD, FlushE};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        RA1D = '0; RA2D = '0; RA1E = '0; RA2E = '0;
        WA3E = '0; WA3M = '0; WA3W = '0;
        RegWriteE = 1'b0; RegWriteM = 1'b0; RegWriteW = 1'b0;
        MemtoRegE = 1'b0; BranchTakenE = 1'b0; mem_busy = 1'b0;
    endtask

    task automatic set_load_use();
        WA3E = 4'd3; RegWriteE = 1'b1; MemtoRegE = 1'b1; RA1D = 4'd3;
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 1'b0;
        #3;
        n_cmp++;
        if (strb !== 6'b000011) begin
            n_bad++; $display("FAIL rst_low_strobes got %b want %b", strb, 6'b000011);
        end
        n_cmp++;
        if (state_o !== 2'(RUN)) begin
            n_bad++; $display("FAIL rst_low_state got %0d want %0d", state_o, 2'(RUN));
        end
        tick();
        reset = 1'b1;
        #1;
        n_cmp++;
        if (strb !== 6'b000000) begin
            n_bad++; $display("FAIL rst_rel_strobes got %b want %b", strb, 6'b000000);
        end
        n_cmp++;
        if ({ForwardAE, ForwardBE} !== 4'b0000) begin
            n_bad++; $display("FAIL rst_rel_fwd got %b want %b", {ForwardAE, ForwardBE}, 4'b0000);
        end
        tick();
        n_cmp++;
        if (state_o !== 2'(RUN)) begin
            n_bad++; $display("FAIL rst_rel_state got %0d want %0d", state_o, 2'(RUN));
        end
        $display("test_reset done");
    endtask

    task automatic test_load_use();
        clear_inputs();
        set_load_use();
        #1;
        n_cmp++;
        if (strb !== 6'b110001) begin
            n_bad++; $display("FAIL ldu_cause got %b want %b", strb, 6'b110001);
        end
        tick();
        exp_strb = FWD ? 6'b000000 : 6'b110001;
        exp_st   = FWD ? 2'(LDUSE) : 2'(RUN);
        n_cmp++;
        if (state_o !== exp_st) begin
            n_bad++; $display("FAIL ldu_state got %0d want %0d", state_o, exp_st);
        end
        n_cmp++;
        if (strb !== exp_strb) begin
            n_bad++; $display("FAIL ldu_bubble got %b want %b", strb, exp_strb);
        end
        clear_inputs();
        tick();
        n_cmp++;
        if (state_o !== 2'(RUN)) begin
            n_bad++; $display("FAIL ldu_return got %0d want %0d", state_o, 2'(RUN));
        end
        n_cmp++;
        if (strb !== 6'b000000) begin
            n_bad++; $display("FAIL ldu_idle got %b want %b", strb, 6'b000000);
        end
        $display("test_load_use done");
    endtask

    task automatic test_forwarding();
        clear_inputs();
        RegWriteM = 1'b1; WA3M = 4'd5; RegWriteW = 1'b1; WA3W = 4'd5;
        RA2E = 4'd5; RA2D = 4'd5;
        #1;
        exp_fwd  = FWD ? 2'b10 : 2'b00;
        exp_strb = FWD ? 6'b000000 : 6'b110001;
        n_cmp++;
        if (ForwardBE !== exp_fwd) begin
            n_bad++; $display("FAIL fwd_mem got %b want %b", ForwardBE, exp_fwd);
        end
        n_cmp++;
        if (strb !== exp_strb) begin
            n_bad++; $display("FAIL fwd_mem_strobes got %b want %b", strb, exp_strb);
        end
        n_cmp++;
        if (ForwardAE !== 2'b00) begin
            n_bad++; $display("FAIL fwd_a_idle got %b want %b", ForwardAE, 2'b00);
        end
        WA3M = 4'd6;
        RA1E = 4'd5;
        #1;
        exp_fwd = FWD ? 2'b01 : 2'b00;
        n_cmp++;
        if (ForwardBE !== exp_fwd) begin
            n_bad++; $display("FAIL fwd_wb got %b want %b", ForwardBE, exp_fwd);
        end
        n_cmp++;
        if (ForwardAE !== exp_fwd) begin
            n_bad++; $display("FAIL fwd_a_wb got %b want %b", ForwardAE, exp_fwd);
        end
        n_cmp++;
        if (strb !== 6'b000000) begin
            n_bad++; $display("FAIL fwd_wb_strobes got %b want %b", strb, 6'b000000);
        end
        RA2E = 4'd0; RA2D = 4'd0; WA3W = 4'd0; WA3M = 4'd0;
        #1;
        n_cmp++;
        if (ForwardBE !== 2'b00) begin
            n_bad++; $display("FAIL fwd_r0 got %b want %b", ForwardBE, 2'b00);
        end
        clear_inputs();
        tick();
        $display("test_forwarding done");
    endtask

    task automatic test_branch();
        clear_inputs();
        BranchTakenE = 1'b1;
        #1;
        n_cmp++;
        if (strb !== 6'b000011) begin
            n_bad++; $display("FAIL br_cause got %b want %b", strb, 6'b000011);
        end
        tick();
        n_cmp++;
        if (state_o !== 2'(BFLUSH)) begin
            n_bad++; $display("FAIL br_state got %0d want %0d", state_o, 2'(BFLUSH));
        end
        n_cmp++;
        if (strb !== 6'b000011) begin
            n_bad++; $display("FAIL br_hold got %b want %b", strb, 6'b000011);
        end
        tick();
        BranchTakenE = 1'b0;
        #1;
        n_cmp++;
        if (state_o !== 2'(RUN)) begin
            n_bad++; $display("FAIL br_ignore2 got %0d want %0d", state_o, 2'(RUN));
        end
        n_cmp++;
        if (strb !== 6'b000000) begin
            n_bad++; $display("FAIL br_end got %b want %b", strb, 6'b000000);
        end
        tick();
        $display("test_branch done");
    endtask

    task automatic test_mem_busy();
        clear_inputs();
        set_load_use();
        mem_busy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            exp_st = (i == 0) ? 2'(RUN) : 2'(MEMWAIT);
            n_cmp++;
            if (strb !== 6'b111100) begin
                n_bad++; $display("FAIL mb_stall[%0d] got %b want %b", i, strb, 6'b111100);
            end
            n_cmp++;
            if (state_o !== exp_st) begin
                n_bad++; $display("FAIL mb_state[%0d] got %0d want %0d", i, state_o, exp_st);
            end
            tick();
        end
        mem_busy = 1'b0;
        #1;
        n_cmp++;
        if (strb !== 6'b110001) begin
            n_bad++; $display("FAIL mb_release got %b want %b", strb, 6'b110001);
        end
        tick();
        exp_st   = FWD ? 2'(LDUSE) : 2'(RUN);
        exp_strb = FWD ? 6'b000000 : 6'b110001;
        n_cmp++;
        if (state_o !== exp_st) begin
            n_bad++; $display("FAIL mb_after_state got %0d want %0d", state_o, exp_st);
        end
        n_cmp++;
        if (strb !== exp_strb) begin
            n_bad++; $display("FAIL mb_after_strobes got %b want %b", strb, exp_strb);
        end
        clear_inputs();
        tick();
        $display("test_mem_busy done");
    endtask

    task automatic test_branch_mem_busy();
        clear_inputs();
        BranchTakenE = 1'b1;
        tick();
        BranchTakenE = 1'b0;
        mem_busy = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            n_cmp++;
            if (strb !== 6'b111100) begin
                n_bad++; $display("FAIL bm_stall[%0d] got %b want %b", i, strb, 6'b111100);
            end
            n_cmp++;
            if (state_o !== 2'(BFLUSH)) begin
                n_bad++; $display("FAIL bm_state[%0d] got %0d want %0d", i, state_o, 2'(BFLUSH));
            end
            tick();
        end
        mem_busy = 1'b0;
        #1;
        n_cmp++;
        if (strb !== 6'b000011) begin
            n_bad++; $display("FAIL bm_frozen got %b want %b", strb, 6'b000011);
        end
        tick();
        n_cmp++;
        if (state_o !== 2'(RUN)) begin
            n_bad++; $display("FAIL bm_end got %0d want %0d", state_o, 2'(RUN));
        end
        $display("test_branch_mem_busy done");
    endtask

    task automatic test_reset_mid_bflush();
        clear_inputs();
        BranchTakenE = 1'b1;
        tick();
        BranchTakenE = 1'b0;
        set_load_use();
        #1;
        n_cmp++;
        if (state_o !== 2'(BFLUSH)) begin
            n_bad++; $display("FAIL rb_pre got %0d want %0d", state_o, 2'(BFLUSH));
        end
        reset = 1'b0;
        #1;
        n_cmp++;
        if (state_o !== 2'(RUN)) begin
            n_bad++; $display("FAIL rb_async_state got %0d want %0d", state_o, 2'(RUN));
        end
        n_cmp++;
        if (strb !== 6'b000011) begin
            n_bad++; $display("FAIL rb_low_strobes got %b want %b", strb, 6'b000011);
        end
        tick();
        n_cmp++;
        if (strb !== 6'b000011) begin
            n_bad++; $display("FAIL rb_low_hold got %b want %b", strb, 6'b000011);
        end
        reset = 1'b1;
        clear_inputs();
        #1;
        n_cmp++;
        if (strb !== 6'b000000) begin
            n_bad++; $display("FAIL rb_release got %b want %b", strb, 6'b000000);
        end
        tick();
        n_cmp++;
        if (state_o !== 2'(RUN)) begin
            n_bad++; $display("FAIL rb_counter_clear got %0d want %0d", state_o, 2'(RUN));
        end
        $display("test_reset_mid_bflush done");
    endtask

    task automatic test_reg_zero();
        clear_inputs();
        RegWriteE = 1'b1; MemtoRegE = 1'b1; WA3E = 4'd0;
        RegWriteM = 1'b1; WA3M = 4'd0; RegWriteW = 1'b1; WA3W = 4'd0;
        #1;
        n_cmp++;
        if (strb !== 6'b000000) begin
            n_bad++; $display("FAIL r0_strobes got %b want %b", strb, 6'b000000);
        end
        n_cmp++;
        if ({ForwardAE, ForwardBE} !== 4'b0000) begin
            n_bad++; $display("FAIL r0_fwd got %b want %b", {ForwardAE, ForwardBE}, 4'b0000);
        end
        clear_inputs();
        tick();
        $display("test_reg_zero done");
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_forwarding();
        test_branch();
        test_mem_busy();
        test_branch_mem_busy();
        test_reset_mid_bflush();
        test_reg_zero();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1);
    end

endmodule
